// File: rtl/sync_delay.sv
// Trigger-to-pulse delay: an accepted sync_in trigger produces one sync_out pulse
// L+1 clock-enabled cycles later, with overrun/miss accounting for triggers that arrive mid-count.
module sync_delay #(
  parameter int CNT_WIDTH  = 16,
  parameter int MISS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  sync_in,
  input  logic [CNT_WIDTH-1:0]  delay_len,
  input  logic                  clr_err,
  output logic                  sync_out,
  output logic                  busy,
  output logic                  overrun,
  output logic [MISS_WIDTH-1:0] miss_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [MISS_WIDTH-1:0] MISS_ONE = MISS_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sync_out_q, sync_out_d;
  logic                   overrun_q, overrun_d;
  logic [MISS_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic cnt_zero;
  logic accept;
  logic ignore;

  assign cnt_zero = (cnt_q == '0);
  // A trigger landing on the final count cycle is accepted, so pulses can chain back to back.
  assign accept   = sync_in && ((state_q == IDLE) || cnt_zero);
  assign ignore   = sync_in && (state_q == COUNT) && !cnt_zero;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_out_d = 1'b0;
    overrun_d  = overrun_q;
    miss_cnt_d = miss_cnt_q;

    if (state_q == COUNT) begin
      if (cnt_zero) begin
        sync_out_d = 1'b1;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    // A new trigger overrides the state/counter update but never cancels a pulse already due.
    if (accept) begin
      if (delay_len == '0) begin
        sync_out_d = 1'b1;
        state_d    = IDLE;
      end else begin
        cnt_d   = delay_len - CNT_ONE;
        state_d = COUNT;
      end
    end

    if (clr_err) begin
      overrun_d  = 1'b0;
      miss_cnt_d = '0;
    end else if (ignore) begin
      overrun_d = 1'b1;
      if (miss_cnt_q != '1) begin
        miss_cnt_d = miss_cnt_q + MISS_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      miss_cnt_q <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_out_q <= sync_out_d;
      overrun_q  <= overrun_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign sync_out = sync_out_q;
  assign busy     = (state_q == COUNT);
  assign overrun  = overrun_q;
  assign miss_cnt = miss_cnt_q;

endmodule
